// File: rtl/char_stream_sequencer.sv
// char_stream_sequencer: buffers character codes and issues them one at a time to a drawer while tracking a text cursor
// Ports: clock, resetn (async active-low); clear (sync flush); wr_en/wr_char push into the FIFO;
//   char_done is the drawer's completion pulse; start_char/char_code/char_col/char_row drive the drawer;
//   full/busy/overflow report FIFO and sequencer status; timeout_err is the sticky watchdog flag.
// Optional: define CHAR_TIMEOUT_EN to force completion after TIMEOUT cycles in WAIT.
module char_stream_sequencer #(
    parameter int DEPTH   = 8,
    parameter int COLS    = 16,
    parameter int ROWS    = 8,
    parameter int COL_W   = 4,
    parameter int ROW_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [7:0]       wr_char,
    input  logic             char_done,
    output logic             start_char,
    output logic [7:0]       char_code,
    output logic [COL_W-1:0] char_col,
    output logic [ROW_W-1:0] char_row,
    output logic             full,
    output logic             busy,
    output logic             overflow,
    output logic             timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             start_q, start_d;
    logic [7:0]       code_q, code_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, tmo_hit;
    logic [7:0]       head;
    logic [ROW_W-1:0] row_inc;

    assign full    = count_q == CW'(DEPTH);
    assign head    = mem_q[rd_ptr_q];
    assign row_inc = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

`ifdef CHAR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;

    // The counter is zero on entry to WAIT, so the TIMEOUT-th cycle spent there forces completion.
    assign tmo_hit     = state_q == WAIT && !char_done && tcnt_q == TW'(TIMEOUT - 1);
    assign timeout_err = tmo_q;

    always_comb begin
        tcnt_d = (state_q == WAIT && !clear) ? tcnt_q + TW'(1) : '0;
        tmo_d  = !clear && (tmo_q || tmo_hit);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    // Never true; keeps TIMEOUT referenced while the watchdog is compiled out.
    assign timeout_err = (TIMEOUT < 0);
`endif

    always_comb begin
        push       = wr_en && !full;
        pop        = 1'b0;
        state_d    = state_q;
        start_d    = 1'b0;
        code_d     = code_q;
        col_d      = col_q;
        row_d      = row_q;
        overflow_d = overflow_q || (wr_en && full);
        if (state_q == IDLE && count_q != '0) begin
            pop = 1'b1;
            if (head == 8'h0A) begin
                col_d = '0;
                row_d = row_inc;
            end else begin
                code_d  = head;
                start_d = 1'b1;
                state_d = WAIT;
            end
        end else if (state_q == WAIT && (char_done || tmo_hit)) begin
            state_d = IDLE;
            col_d   = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
            row_d   = (col_q == COL_W'(COLS - 1)) ? row_inc : row_q;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (clear) begin
            state_d    = IDLE;
            start_d    = 1'b0;
            code_d     = '0;
            col_d      = '0;
            row_d      = '0;
            overflow_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            start_q    <= 1'b0;
            code_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            start_q    <= start_d;
            code_q     <= code_d;
            col_q      <= col_d;
            row_q      <= row_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers and count decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push && !clear) mem_q[wr_ptr_q] <= wr_char;
    end

    assign start_char = start_q;
    assign char_code  = code_q;
    assign char_col   = col_q;
    assign char_row   = row_q;
    assign busy       = state_q != IDLE || count_q != '0;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_char_stream_sequencer.sv
// tb_char_stream_sequencer: randomized and directed checks of char_stream_sequencer against a queue-based model
module tb_char_stream_sequencer;
    localparam int DEPTH   = 8;
    localparam int COLS    = 16;
    localparam int ROWS    = 8;
    localparam int TIMEOUT = 64;

    logic       clock = 1'b0, resetn = 1'b0, clear = 1'b0, wr_en = 1'b0, char_done = 1'b0;
    logic [7:0] wr_char = '0;
    logic       start_char, full, busy, overflow, timeout_err;
    logic [7:0] char_code;
    logic [3:0] char_col;
    logic [2:0] char_row;

    char_stream_sequencer #(.DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS), .COL_W(4), .ROW_W(3), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .clear(clear), .wr_en(wr_en), .wr_char(wr_char),
        .char_done(char_done), .start_char(start_char), .char_code(char_code), .char_col(char_col),
        .char_row(char_row), .full(full), .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0, n_fail = 0;

    logic [7:0] mq[$];
    bit         m_wait, m_start, m_ovf, m_tmo;
    int         m_col, m_row, m_code, m_wcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_wait = 0; m_start = 0; m_ovf = 0; m_tmo = 0;
        m_col = 0; m_row = 0; m_code = 0; m_wcnt = 0;
    endfunction

    function automatic void model_edge(input bit w, input logic [7:0] c, input bit d, input bit cl);
        bit         was_full;
        bit         fin;
        logic [7:0] ch;
        if (cl) begin
            model_reset();
            return;
        end
        was_full = mq.size() == DEPTH;
        m_start  = 0;
        if (!m_wait && mq.size() > 0) begin
            ch = mq.pop_front();
            if (ch == 8'h0A) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end else begin
                m_code  = ch;
                m_start = 1;
                m_wait  = 1;
                m_wcnt  = 0;
            end
        end else if (m_wait) begin
            fin = d;
`ifdef CHAR_TIMEOUT_EN
            if (!d && m_wcnt == TIMEOUT - 1) begin
                fin   = 1;
                m_tmo = 1;
            end
            m_wcnt++;
`endif
            if (fin) begin
                m_wait = 0;
                m_col++;
                if (m_col == COLS) begin
                    m_col = 0;
                    m_row = (m_row + 1) % ROWS;
                end
            end
        end
        if (w) begin
            if (was_full) m_ovf = 1;
            else mq.push_back(c);
        end
    endfunction

    task automatic compare_all();
        check("start_char", start_char, m_start);
        check("char_code", char_code, m_code);
        check("char_col", char_col, m_col);
        check("char_row", char_row, m_row);
        check("full", full, mq.size() == DEPTH);
        check("busy", busy, m_wait || mq.size() > 0);
        check("overflow", overflow, m_ovf);
        check("timeout_err", timeout_err, m_tmo);
    endtask

    task automatic cyc(input bit w, input logic [7:0] c, input bit d, input bit cl);
        wr_en = w; wr_char = c; char_done = d; clear = cl;
        @(posedge clock);
        model_edge(w, c, d, cl);
        #1;
        compare_all();
    endtask

    int ph_cycles [3] = '{1500, 300, 1500};
    int ph_wr     [3] = '{30, 70, 50};
    int ph_done   [3] = '{30, 3, 60};
    int ph_clr    [3] = '{2, 0, 1};
    int ph_nl     [3] = '{10, 5, 15};

    initial begin
        int starts;
        model_reset();
        #12;
        compare_all();
        resetn = 1'b1;

        // single 'A': pulse one cycle after the write edge, then cursor advances on done
        cyc(1, 8'h41, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("A_start", start_char, 1'b1);
        check("A_code", char_code, 8'h41);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        check("A_col", char_col, 1);
        check("A_busy", busy, 1'b0);

        // H, newline, I
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h48, 0, 0);
        cyc(1, 8'h0A, 0, 0);
        cyc(1, 8'h49, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, (i % 3) == 2, 0);

        // stalled drawer: DEPTH+2 writes -> full, overflow, DEPTH+1 characters drawn
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH + 2; i++) cyc(1, 8'h61 + 8'(i), 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("stall_full", full, 1'b1);
        check("stall_ovf", overflow, 1'b1);
        starts = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 8'h00, 1, 0);
            if (start_char) starts++;
        end
        check("stall_drawn", starts, DEPTH + 1);

        // clear mid-WAIT with chars queued
        cyc(1, 8'h31, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'h32 + 8'(i), 0, 0);
        cyc(0, 8'h00, 0, 1);
        check("clr_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0);

        // async reset mid-WAIT
        cyc(1, 8'h58, 0, 0);
        cyc(1, 8'h59, 0, 0);
        cyc(0, 8'h00, 0, 0);
        resetn = 1'b0;
        #2;
        model_reset();
        compare_all();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);

`ifdef CHAR_TIMEOUT_EN
        cyc(1, 8'h54, 0, 0);
        for (int i = 0; i < TIMEOUT + 8; i++) cyc(0, 8'h00, 0, 0);
        check("tmo_flag", timeout_err, 1'b1);
        check("tmo_col", char_col, 1);
        cyc(0, 8'h00, 0, 1);
`endif

        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < ph_cycles[p]; i++) begin
                bit         w, d, cl;
                logic [7:0] c;
                w  = ($urandom % 100) < ph_wr[p];
                d  = ($urandom % 100) < ph_done[p];
                cl = ($urandom % 1000) < ph_clr[p];
                c  = (($urandom % 100) < ph_nl[p]) ? 8'h0A : 8'($urandom_range(32, 126));
                cyc(w, c, d, cl);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/char_stream_sequencer.md
Name: char_stream_sequencer

Overview:
Source side of the per-character drawing handshake. Buffers character codes written by the CPU/VGA glue in a small FIFO. Issues one character at a time to the character drawer as a code plus a one-cycle start pulse with the cursor position, then waits for the drawer's finishedCharacter pulse. Keeps a text cursor (column/row) with line wrap, newline handling and screen wrap.

Parameters:
DEPTH, 8, FIFO entries (power of 2)
COLS, 16, character columns per row
ROWS, 8, character rows per screen
COL_W, 4, width of char_col (>= clog2(COLS))
ROW_W, 3, width of char_row (>= clog2(ROWS))
TIMEOUT, 64, max cycles waiting for char_done (optional feature only)

Ports:
clock  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous flush: empty FIFO, cursor to 0,0, state IDLE
wr_en  input  1  push wr_char this cycle
wr_char  input  8  character code to push
char_done  input  1  one-cycle finishedCharacter pulse from drawer
start_char  output  1  one-cycle pulse: drawer begins char_code at char_col/char_row
char_code  output  8  code being drawn, stable from start_char until char_done
char_col  output  COL_W  cursor column of current character
char_row  output  ROW_W  cursor row of current character
full  output  1  FIFO holds DEPTH entries
busy  output  1  state != IDLE or FIFO not empty
overflow  output  1  sticky: write attempted while full
timeout_err  output  1  sticky watchdog flag (0 when feature off)

Behaviour:
- Reset (resetn low, async): all outputs 0; FIFO empty; state IDLE; cursor 0,0. clear has identical effect, synchronous, and has priority over wr_en and char_done in the same cycle.
- FIFO: write when wr_en && !full. wr_en while full: data dropped, overflow <= 1 until reset/clear. Full is judged on the pre-edge count: a write while full is dropped even if a pop happens the same cycle. Simultaneous push and pop when not full: count unchanged.
- States: IDLE, WAIT.
- IDLE, FIFO empty: hold.
- IDLE, FIFO not empty, head == 8'h0A (newline): pop; char_col <= 0; char_row <= row+1, wrapping ROWS-1 -> 0. No start_char. Stay IDLE.
- IDLE, FIFO not empty, other code: pop; char_code <= head; start_char <= 1 for exactly one cycle; go to WAIT.
- Latency: write at edge N into an empty FIFO with state IDLE -> start_char high after edge N+1, low after edge N+2.
- WAIT: on char_done -> advance cursor and go to IDLE. Advance means col+1; at col == COLS-1, col <= 0 and row+1 (wrapping to 0 after ROWS-1). char_code, char_col and char_row do not change while in WAIT.
- A char_done seen in the same cycle that start_char is high counts as completion.
- A char_done seen in IDLE is ignored.
- Back-to-back: after char_done at edge M (state returns to IDLE), the next start_char comes at edge M+1. Minimum of 2 cycles per character.
- clear or reset during WAIT abandons the current character. No further start_char until a new write.

Optional Feature:
CHAR_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT. If TIMEOUT cycles pass with no char_done, behave as if char_done arrived (advance cursor, go IDLE) and set timeout_err <= 1 (sticky until reset/clear).
- Not defined: WAIT lasts until char_done. No counter logic. timeout_err is tied to 0.

Test Plan:
- Reset, then write 'A' (8'h41) -> start_char pulses 1 cycle after the write edge; char_code=8'h41, col=0, row=0; busy=1 until char_done, then busy=0, col=1.
- Write 17 non-newline chars, drive char_done 11 cycles after each start_char -> chars 0-15 on row 0 at cols 0-15; char 16 at col 0, row 1.
- Write 'H', 8'h0A, 'I' -> 'H' at 0,0; no start_char for the newline; 'I' at col 0, row 1.
- Cursor at col 15, row 7, write 'Z', then char_done -> cursor wraps to 0,0.
- With the drawer stalled, do DEPTH+2 writes -> full=1 after the FIFO fills; overflow=1; exactly DEPTH+1 characters drawn once the drawer resumes (one already issued plus DEPTH buffered).
- Pulse clear mid-WAIT with 3 chars queued -> busy=0, cursor 0,0, no start_char afterwards. With CHAR_TIMEOUT_EN and char_done never driven -> cursor advances after 64 cycles and timeout_err=1.
